// File: rtl/shift_sequencer.sv
// shift_sequencer: shifts a signed WIDTH-bit operand by a signed amount over several cycles, using a start/done handshake. A start seen while busy is dropped, not queued.
// Latency is N+1 cycles, where N = min(|amount|, WIDTH). Defining SHIFT_SEQ_STEP4_EN adds 4-bit steps, giving floor(N/4)+(N mod 4)+1.
module shift_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] src,
  input  logic [WIDTH-1:0] shiftAmount,
  input  logic             shiftType,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [CW-1:0]    n_launch;
  logic [WIDTH-1:0] amt_mag;
  logic [2:0]       step;
  logic             dir_left;
  logic             logical;

  // Two's-complement magnitude; 0x8000 maps onto itself and therefore saturates to WIDTH.
  assign amt_mag  = shiftAmount[WIDTH-1] ? (~shiftAmount + 1'b1) : shiftAmount;
  assign n_launch = (amt_mag >= WIDTH'(WIDTH)) ? CW'(WIDTH) : amt_mag[CW-1:0];

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] v,
                                                input logic left,
                                                input logic lgc,
                                                input logic [2:0] k);
    logic [WIDTH-1:0] r;
    if (left)     r = v << k;
    else if (lgc) r = v >> k;
    else          r = WIDTH'($signed(v) >>> k);
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    step      = 3'd1;
    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt   = src;
          cnt_nxt   = n_launch;
          state_nxt = (n_launch == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
`ifdef SHIFT_SEQ_STEP4_EN
        if (cnt >= CW'(4)) step = 3'd4;
`endif
        acc_nxt = shift_by(acc, dir_left, logical, step);
        cnt_nxt = cnt - CW'(step);
        if (cnt_nxt == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      dir_left <= 1'b0;
      logical  <= 1'b0;
      result   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && start) begin
        dir_left <= ~shiftAmount[WIDTH-1];
        logical  <= shiftType;
      end
      // DONE always exits to IDLE, so this fires only on the entry edge.
      if (state_nxt == DONE) result <= acc_nxt;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
